// File: rtl/gfx256_pkg.sv
// Shared types and constants for the gfx256 read-side Wishbone master.
package gfx256_pkg;

    localparam int LINE_W   = 256;  // returned line width in bits
    localparam int OFF_BITS = 5;    // byte offset bits within one 32-byte line
    localparam int TO_W     = 10;   // width of the bus timeout counter

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Line-aligned byte address (offset bits forced to zero).
    function automatic logic [31:0] line_base(input logic [31:0] addr);
        return {addr[31:OFF_BITS], {OFF_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/gfx256_rr_arbiter.sv
// Combinational round-robin pick: the search starts at last_grant+1 and wraps.
module gfx256_rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    // First requester after last_grant wins; later hits are ignored.
    always_comb begin
        int unsigned   cand;
        logic [IW-1:0] c;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = 0;
        c         = '0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(last_grant) + k) % N;
            c    = IW'(cand);
            if (!any && req[c]) begin
                any       = 1'b1;
                grant[c]  = 1'b1;
                grant_idx = c;
            end
        end
    end

endmodule

// File: rtl/gfx256_wbm_reader.sv
// Round-robin 256-bit line reader acting as a classic Wishbone read master.
// Optional one-line read cache enabled by defining GFX256_RDCACHE_EN.
module gfx256_wbm_reader
    import gfx256_pkg::*;
#(
    parameter int NCLIENT = 3,
    parameter int TIMEOUT = 1023
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NCLIENT-1:0]    req_i,
    input  logic [NCLIENT*32-1:0] addr_i,
    input  logic [NCLIENT*32-1:0] sel_i,
    output logic [NCLIENT-1:0]    ack_o,
    output logic [LINE_W-1:0]     data_o,
    output logic                  busy_o,
    output logic                  err_o,
    output logic                  m_cyc_o,
    output logic                  m_stb_o,
    output logic                  m_we_o,
    output logic [31:0]           m_adr_o,
    output logic [31:0]           m_sel_o,
    input  logic [LINE_W-1:0]     m_dat_i,
    input  logic                  m_ack_i,
    input  logic                  m_err_i,
    input  logic                  inval_i
);

    localparam int IW = (NCLIENT > 1) ? $clog2(NCLIENT) : 1;

    logic [31:0] addr_arr [NCLIENT];
    logic [31:0] sel_arr  [NCLIENT];

    // Split the flat per-client buses into indexable arrays.
    for (genvar gi = 0; gi < NCLIENT; gi++) begin : g_split
        assign addr_arr[gi] = addr_i[32*gi +: 32];
        assign sel_arr[gi]  = sel_i[32*gi +: 32];
    end

    state_t              state_reg, state_next;
    logic [IW-1:0]       last_grant_reg, last_grant_next;
    logic [IW-1:0]       grant_reg, grant_next;
    logic [31:0]         adr_reg, adr_next;
    logic [31:0]         sel_reg, sel_next;
    logic [LINE_W-1:0]   data_reg, data_next;
    logic [NCLIENT-1:0]  ack_reg, ack_next;
    logic                err_reg, err_next;
    logic [TO_W-1:0]     cnt_reg, cnt_next;
    logic                timeout_hit;

    logic [NCLIENT-1:0]  arb_grant;
    logic [IW-1:0]       arb_idx;
    logic                arb_any;

    gfx256_rr_arbiter #(
        .N  (NCLIENT),
        .IW (IW)
    ) u_arb (
        .req        (req_i),
        .last_grant (last_grant_reg),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .any        (arb_any)
    );

`ifdef GFX256_RDCACHE_EN
    logic                cache_valid_reg, cache_valid_next;
    logic [31:OFF_BITS]  cache_tag_reg, cache_tag_next;
    logic [LINE_W-1:0]   cache_line_reg, cache_line_next;
    logic                cache_hit;

    // Hit when the tag of the address being granted matches the held line.
    assign cache_hit = cache_valid_reg &&
                       (cache_tag_reg == addr_arr[arb_idx][31:OFF_BITS]);

    logic unused_sink;
    assign unused_sink = ^adr_reg[OFF_BITS-1:0];
`else
    logic unused_sink;
    assign unused_sink = ^{adr_reg[OFF_BITS-1:0], inval_i};
`endif

    assign timeout_hit = (cnt_reg == TO_W'(TIMEOUT - 1));

    // Next-state and datapath updates for the IDLE/BUS/DONE controller.
    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        grant_next      = grant_reg;
        adr_next        = adr_reg;
        sel_next        = sel_reg;
        data_next       = data_reg;
        ack_next        = '0;
        err_next        = err_reg;
        cnt_next        = cnt_reg;
`ifdef GFX256_RDCACHE_EN
        cache_valid_next = cache_valid_reg;
        cache_tag_next   = cache_tag_reg;
        cache_line_next  = cache_line_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (arb_any) begin
                    last_grant_next = arb_idx;
                    grant_next      = arb_idx;
                    adr_next        = addr_arr[arb_idx];
                    sel_next        = sel_arr[arb_idx];
                    cnt_next        = '0;
`ifdef GFX256_RDCACHE_EN
                    if (cache_hit) begin
                        data_next  = cache_line_reg;
                        ack_next   = arb_grant;
                        state_next = DONE;
                    end else begin
                        state_next = BUS;
                    end
`else
                    state_next = BUS;
`endif
                end
            end
            BUS: begin
                // Error and timeout outrank a simultaneous ack.
                if (m_err_i || timeout_hit) begin
                    data_next            = '0;
                    ack_next[grant_reg]  = 1'b1;
                    err_next             = 1'b1;
                    state_next           = DONE;
`ifdef GFX256_RDCACHE_EN
                    cache_valid_next     = 1'b0;
`endif
                end else if (m_ack_i) begin
                    data_next            = m_dat_i;
                    ack_next[grant_reg]  = 1'b1;
                    state_next           = DONE;
`ifdef GFX256_RDCACHE_EN
                    cache_valid_next     = 1'b1;
                    cache_tag_next       = adr_reg[31:OFF_BITS];
                    cache_line_next      = m_dat_i;
`endif
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                // One dead cycle lets the acked client drop its request.
                state_next = IDLE;
                cnt_next   = '0;
            end
            default: state_next = IDLE;
        endcase
`ifdef GFX256_RDCACHE_EN
        if (inval_i) begin
            cache_valid_next = 1'b0;
        end
`endif
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_reg      <= IDLE;
            last_grant_reg <= IW'(NCLIENT - 1);
            grant_reg      <= '0;
            adr_reg        <= '0;
            sel_reg        <= '0;
            data_reg       <= '0;
            ack_reg        <= '0;
            err_reg        <= 1'b0;
            cnt_reg        <= '0;
`ifdef GFX256_RDCACHE_EN
            cache_valid_reg <= 1'b0;
            cache_tag_reg   <= '0;
            cache_line_reg  <= '0;
`endif
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            grant_reg      <= grant_next;
            adr_reg        <= adr_next;
            sel_reg        <= sel_next;
            data_reg       <= data_next;
            ack_reg        <= ack_next;
            err_reg        <= err_next;
            cnt_reg        <= cnt_next;
`ifdef GFX256_RDCACHE_EN
            cache_valid_reg <= cache_valid_next;
            cache_tag_reg   <= cache_tag_next;
            cache_line_reg  <= cache_line_next;
`endif
        end
    end

    assign ack_o   = ack_reg;
    assign data_o  = data_reg;
    assign busy_o  = (state_reg != IDLE);
    assign err_o   = err_reg;
    assign m_cyc_o = (state_reg == BUS);
    assign m_stb_o = (state_reg == BUS);
    assign m_we_o  = 1'b0;
    assign m_adr_o = line_base(adr_reg);
    assign m_sel_o = sel_reg;

endmodule

// File: tb/tb_gfx256_wbm_reader.sv
// Directed bench for gfx256_wbm_reader: vector table plus multi-cycle sequences.
module tb_gfx256_wbm_reader;

    localparam int N = 3;

    logic           clk = 1'b0;
    logic           rst_i;
    logic [N-1:0]   req_i;
    logic [N*32-1:0] addr_i;
    logic [N*32-1:0] sel_i;
    logic [N-1:0]   ack_o;
    logic [255:0]   data_o;
    logic           busy_o;
    logic           err_o;
    logic           m_cyc_o;
    logic           m_stb_o;
    logic           m_we_o;
    logic [31:0]    m_adr_o;
    logic [31:0]    m_sel_o;
    logic [255:0]   m_dat_i;
    logic           m_ack_i;
    logic           m_err_i;
    logic           inval_i;

    gfx256_wbm_reader #(
        .NCLIENT (N),
        .TIMEOUT (1023)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .addr_i  (addr_i),
        .sel_i   (sel_i),
        .ack_o   (ack_o),
        .data_o  (data_o),
        .busy_o  (busy_o),
        .err_o   (err_o),
        .m_cyc_o (m_cyc_o),
        .m_stb_o (m_stb_o),
        .m_we_o  (m_we_o),
        .m_adr_o (m_adr_o),
        .m_sel_o (m_sel_o),
        .m_dat_i (m_dat_i),
        .m_ack_i (m_ack_i),
        .m_err_i (m_err_i),
        .inval_i (inval_i)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int           client;
        logic [31:0]  addr;
        logic [31:0]  sel;
        int           delay;
        logic         ack;
        logic         err;
        logic [255:0] dat;
        logic [31:0]  exp_adr;
        logic [2:0]   exp_ack;
        logic [255:0] exp_data;
        logic         exp_err;
    } vec_t;

    vec_t vecs[6];

    function automatic vec_t mk(input int c, input logic [31:0] a, input logic [31:0] s,
                                input int d, input logic ak, input logic er,
                                input logic [255:0] dt, input logic [31:0] ea,
                                input logic [2:0] eak, input logic [255:0] ed,
                                input logic ee);
        vec_t v;
        v.client = c;  v.addr = a;  v.sel = s;  v.delay = d;
        v.ack = ak;    v.err = er;  v.dat = dt;
        v.exp_adr = ea; v.exp_ack = eak; v.exp_data = ed; v.exp_err = ee;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input string name);
        int i = 0;
        while (!m_cyc_o && i < 20) begin
            tick;
            i++;
        end
        chk(name, m_cyc_o, 1'b1);
    endtask

    task automatic do_reset;
        rst_i   = 1'b0;
        req_i   = '0;
        m_ack_i = 1'b0;
        m_err_i = 1'b0;
        m_dat_i = '0;
        inval_i = 1'b0;
        repeat (3) tick;
        rst_i = 1'b1;
        tick;
    endtask

    // One complete bus read driven from a vector, checked at every phase.
    task automatic run_vec(input vec_t v, input string tag);
        req_i[v.client] = 1'b1;
        addr_i[32*v.client +: 32] = v.addr;
        sel_i[32*v.client +: 32]  = v.sel;
        wait_cyc({tag, "_cyc"});
        chk({tag, "_stb"}, m_stb_o, 1'b1);
        chk({tag, "_we"}, m_we_o, 1'b0);
        chk({tag, "_adr"}, m_adr_o, v.exp_adr);
        chk({tag, "_sel"}, m_sel_o, v.sel);
        chk({tag, "_busy"}, busy_o, 1'b1);
        repeat (v.delay) tick;
        chk({tag, "_cyc_hold"}, m_cyc_o, 1'b1);
        m_ack_i = v.ack;
        m_err_i = v.err;
        m_dat_i = v.dat;
        tick;
        m_ack_i = 1'b0;
        m_err_i = 1'b0;
        m_dat_i = '0;
        chk({tag, "_ack"}, ack_o, v.exp_ack);
        chk({tag, "_data"}, data_o, v.exp_data);
        chk({tag, "_err"}, err_o, v.exp_err);
        chk({tag, "_cyc_drop"}, m_cyc_o, 1'b0);
        req_i[v.client] = 1'b0;
        tick;
        chk({tag, "_ack_clr"}, ack_o, 3'b000);
        chk({tag, "_data_hold"}, data_o, v.exp_data);
        chk({tag, "_idle"}, busy_o, 1'b0);
        $display("[TB] %s client=%0d adr=%h ack=%0d err=%0d", tag, v.client, v.exp_adr, v.ack, v.err);
    endtask

    initial begin
        int     order[$];
        int     times[$];
        int     exp_order[4];
        int     t;
        int     idx;
        int     ncyc;
        int     guard;
        bit     rereq;
        bit     pend;
        logic [255:0] expd;
        vec_t   v;

        addr_i = '0;
        sel_i  = '0;
        vecs[0] = mk(1, 32'h0000_1234, 32'hFFFF_FFFF, 3, 1'b1, 1'b0, {8{32'hA5A5_0001}},
                     32'h0000_1220, 3'b010, {8{32'hA5A5_0001}}, 1'b0);
        vecs[1] = mk(2, 32'hDEAD_BEEF, 32'h0000_00FF, 0, 1'b1, 1'b0, {8{32'h1234_5678}},
                     32'hDEAD_BEE0, 3'b100, {8{32'h1234_5678}}, 1'b0);
        vecs[2] = mk(0, 32'h8000_001F, 32'hF0F0_0000, 1, 1'b1, 1'b0, {4{64'hCAFE_F00D_0BAD_BEEF}},
                     32'h8000_0000, 3'b001, {4{64'hCAFE_F00D_0BAD_BEEF}}, 1'b0);
        vecs[3] = mk(0, 32'h0000_0040, 32'hFFFF_FFFF, 2, 1'b0, 1'b1, {8{32'h5555_AAAA}},
                     32'h0000_0040, 3'b001, 256'h0, 1'b1);
        vecs[4] = mk(1, 32'h1000_0020, 32'h0000_0001, 0, 1'b1, 1'b1, {8{32'h7777_7777}},
                     32'h1000_0020, 3'b010, 256'h0, 1'b1);
        vecs[5] = mk(2, 32'h2000_0005, 32'h0000_0003, 4, 1'b1, 1'b0, {8{32'h0F0F_1E1E}},
                     32'h2000_0000, 3'b100, {8{32'h0F0F_1E1E}}, 1'b1);

        // Reset state
        do_reset;
        chk("rst_ack", ack_o, 3'b000);
        chk("rst_data", data_o, 256'h0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_cyc", m_cyc_o, 1'b0);
        chk("rst_stb", m_stb_o, 1'b0);
        chk("rst_adr", m_adr_o, 32'h0);
        chk("rst_sel", m_sel_o, 32'h0);

        // Vector table: single-client reads, error, error+ack, sticky error
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Round robin: all three request, client0 re-requests after its ack
        do_reset;
        addr_i = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
        sel_i  = {3{32'hFFFF_FFFF}};
        req_i  = 3'b111;
        exp_order = '{0, 1, 2, 0};
        t = 0; rereq = 1'b0; pend = 1'b0;
        while (order.size() < 4 && t < 60) begin
            if (ack_o != 3'b000) begin
                chk("rr_onehot", $countones(ack_o), 1);
                idx = 0;
                for (int k = 0; k < N; k++) if (ack_o[k]) idx = k;
                expd = {8{32'h100 * (idx + 1)}};
                chk($sformatf("rr_data%0d", order.size()), data_o, expd);
                order.push_back(idx);
                times.push_back(t);
                req_i[idx] = 1'b0;
                if (idx == 0 && !rereq) pend = 1'b1;
                $display("[TB] rr ack client=%0d at cycle %0d", idx, t);
            end else if (pend) begin
                req_i[0] = 1'b1;
                rereq = 1'b1;
                pend = 1'b0;
            end
            m_ack_i = m_cyc_o;
            m_dat_i = {8{m_adr_o}};
            tick;
            t++;
        end
        m_ack_i = 1'b0;
        req_i = '0;
        chk("rr_count", order.size(), 4);
        for (int i = 0; i < order.size(); i++) begin
            chk($sformatf("rr_order%0d", i), order[i], exp_order[i]);
            if (i > 0) chk($sformatf("rr_gap%0d", i), times[i] - times[i-1], 3);
        end
        tick; tick;

        // Timeout: good read first so data_o is non-zero, then a silent slave
        do_reset;
        v = mk(2, 32'h0000_0ABC, 32'h0000_FFFF, 1, 1'b1, 1'b0, {8{32'hBEEF_0002}},
               32'h0000_0AA0, 3'b100, {8{32'hBEEF_0002}}, 1'b0);
        run_vec(v, "pre_to");
        req_i[2] = 1'b1;
        wait_cyc("to_cyc");
        ncyc = 0; guard = 0;
        while (ack_o == 3'b000 && guard < 1100) begin
            if (m_cyc_o) ncyc++;
            tick;
            guard++;
        end
        chk("to_cycles", ncyc, 1023);
        chk("to_ack", ack_o, 3'b100);
        chk("to_data", data_o, 256'h0);
        chk("to_err", err_o, 1'b1);
        chk("to_cyc_drop", m_cyc_o, 1'b0);
        req_i[2] = 1'b0;
        tick;
        tick;
        chk("to_err_sticky", err_o, 1'b1);
        $display("[TB] timeout client=2 bus_cycles=%0d", ncyc);

        // Reset asserted mid-BUS, coinciding with a slave ack
        addr_i[31:0] = 32'h0000_0660;
        req_i[0] = 1'b1;
        wait_cyc("mr_cyc");
        tick;
        rst_i   = 1'b0;
        m_ack_i = 1'b1;
        m_dat_i = {8{32'hDEAD_0001}};
        tick;
        m_ack_i = 1'b0;
        req_i   = '0;
        chk("mr_cyc_drop", m_cyc_o, 1'b0);
        chk("mr_stb_drop", m_stb_o, 1'b0);
        chk("mr_ack", ack_o, 3'b000);
        chk("mr_err", err_o, 1'b0);
        chk("mr_data", data_o, 256'h0);
        chk("mr_adr", m_adr_o, 32'h0);
        rst_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk($sformatf("mr_noack%0d", i), ack_o, 3'b000);
        end
        chk("mr_err_after", err_o, 1'b0);
        $display("[TB] reset mid-bus done");

`ifdef GFX256_RDCACHE_EN
        // Cache: fill from 0x400, hit on 0x41C, then invalidate and re-read
        do_reset;
        v = mk(0, 32'h0000_0400, 32'hFFFF_FFFF, 1, 1'b1, 1'b0, {8{32'hC0C0_0400}},
               32'h0000_0400, 3'b001, {8{32'hC0C0_0400}}, 1'b0);
        run_vec(v, "c_fill");
        addr_i[63:32] = 32'h0000_041C;
        sel_i[63:32]  = 32'hFFFF_FFFF;
        req_i[1] = 1'b1;
        tick;
        chk("c_hit_ack", ack_o, 3'b010);
        chk("c_hit_data", data_o, {8{32'hC0C0_0400}});
        chk("c_hit_nobus", m_cyc_o, 1'b0);
        req_i[1] = 1'b0;
        tick;
        chk("c_hit_ack_clr", ack_o, 3'b000);
        chk("c_hit_nobus2", m_cyc_o, 1'b0);
        $display("[TB] cache hit client=1 adr=0000041c");
        inval_i = 1'b1;
        tick;
        inval_i = 1'b0;
        v = mk(1, 32'h0000_041C, 32'hFFFF_FFFF, 0, 1'b1, 1'b0, {8{32'hC0C0_0401}},
               32'h0000_0400, 3'b010, {8{32'hC0C0_0401}}, 1'b0);
        run_vec(v, "c_reread");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
